// File: rtl/nettlp_cmd_pkg.sv
// Shared types for the NetTLP command register file: command word layout,
// opcodes, FSM states, adapter register indices and small helpers.
package nettlp_cmd_pkg;

  localparam int CMD_ADDR_W = 8;

  localparam logic [7:0] NETTLP_OPC_REG_RD  = 8'h01;
  localparam logic [7:0] NETTLP_OPC_REG_WR  = 8'h02;
  localparam logic [7:0] NETTLP_OPC_REG_ERR = 8'h03;

  localparam logic [31:0] NETTLP_ERR_DATA = 32'hDEADBEEF;

  // Register map of the adapter instance (used for its RST_VAL / RO_MASK)
  localparam int ADAPTER_REG_MAGIC    = 0;
  localparam int ADAPTER_REG_DST_MAC0 = 1;
  localparam int ADAPTER_REG_DST_MAC1 = 2;
  localparam int ADAPTER_REG_SRC_IP   = 3;
  localparam int ADAPTER_REG_DST_IP   = 4;
  localparam int ADAPTER_REG_REQ_ID   = 5;

  typedef struct packed {
    logic [7:0]            opcode;
    logic [CMD_ADDR_W-1:0] dwaddr;
    logic [3:0]            be;
    logic [31:0]           data;
  } FIFO_NETTLP_CMD_T;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2
  } cmd_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nettlp_cmd_reg_bank.sv
// Register storage: byte-enabled command writes, whole-word hardware updates,
// flat export of all registers with no extra latency.
module nettlp_cmd_reg_bank #(
  parameter int                       NUM_REGS = 16,
  parameter int                       IDX_W    = 4,
  parameter logic [NUM_REGS*32-1:0]   RST_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_we,
  input  logic [IDX_W-1:0]         cmd_idx,
  input  logic [3:0]               cmd_be,
  input  logic [31:0]              cmd_wdata,
  input  logic [NUM_REGS-1:0]      hw_we,
  input  logic [NUM_REGS*32-1:0]   hw_din,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
    logic [31:0] word_q;
    logic        cmd_sel;

    assign cmd_sel = cmd_we && (cmd_idx == IDX_W'(gi));

    // A command write owns the register for that cycle; hardware update is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_q <= RST_VAL[32*gi +: 32];
      end else if (cmd_sel) begin
        for (int b = 0; b < 4; b++) begin
          if (cmd_be[b]) word_q[8*b +: 8] <= cmd_wdata[8*b +: 8];
        end
      end else if (hw_we[gi]) begin
        word_q <= hw_din[32*gi +: 32];
      end
    end

    assign reg_q[32*gi +: 32] = word_q;
  end

endmodule

// File: rtl/nettlp_cmd_regfile.sv
// Command-driven register file: pops register read/write commands from the
// cmd RX FIFO, executes them against the bank and pushes replies to cmd TX.
module nettlp_cmd_regfile
  import nettlp_cmd_pkg::*;
#(
  parameter int                     NUM_REGS   = 16,
  parameter int                     ADDR_W     = 8,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = 16'h0001,
  parameter logic [NUM_REGS*32-1:0] RST_VAL    = {{15{32'h0}}, 32'h01234567},
  parameter bit                     SWAP_BYTES = 1'b1,
  parameter bit                     WR_ACK     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_cmd_i_rd_en,
  input  logic                   fifo_cmd_i_empty,
  input  FIFO_NETTLP_CMD_T       fifo_cmd_i_dout,
  output logic                   fifo_cmd_o_wr_en,
  input  logic                   fifo_cmd_o_full,
  output FIFO_NETTLP_CMD_T       fifo_cmd_o_din,
  output logic [NUM_REGS*32-1:0] reg_q,
  input  logic [NUM_REGS-1:0]    hw_we,
  input  logic [NUM_REGS*32-1:0] hw_din,
  output logic [15:0]            stat_cmd_cnt,
  output logic [15:0]            stat_err_cnt
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  cmd_state_e       state_q, state_d;
  FIFO_NETTLP_CMD_T cmd_q, cmd_d;
  FIFO_NETTLP_CMD_T reply_q, reply_d;
  logic [15:0]      cmd_cnt_q, cmd_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0] idx;
  logic             addr_ok;
  logic             is_ro;
  logic [31:0]      cur_word;
  logic [31:0]      wr_word;
  logic [31:0]      merged_word;
  logic [31:0]      rd_wire;
  logic [31:0]      new_wire;
  logic             bank_we;

  assign idx      = cmd_q.dwaddr[IDX_W-1:0];
  assign addr_ok  = (ADDR_W + 1)'(cmd_q.dwaddr) < (ADDR_W + 1)'(NUM_REGS);
  assign is_ro    = RO_MASK[idx];
  assign cur_word = reg_q[{idx, 5'd0} +: 32];
  assign wr_word  = SWAP_BYTES ? bswap32(cmd_q.data) : cmd_q.data;
  assign rd_wire  = SWAP_BYTES ? bswap32(cur_word) : cur_word;

  // Post-write register value, needed only for the write acknowledge echo.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_merge
    assign merged_word[8*gi +: 8] = cmd_q.be[gi] ? wr_word[8*gi +: 8] : cur_word[8*gi +: 8];
  end
  assign new_wire = SWAP_BYTES ? bswap32(merged_word) : merged_word;

  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    reply_d          = reply_q;
    cmd_cnt_d        = cmd_cnt_q;
    err_cnt_d        = err_cnt_q;
    fifo_cmd_i_rd_en = 1'b0;
    fifo_cmd_o_wr_en = 1'b0;
    bank_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_cmd_i_empty) begin
          fifo_cmd_i_rd_en = 1'b1;
          cmd_d            = fifo_cmd_i_dout;
          cmd_cnt_d        = sat_inc16(cmd_cnt_q);
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if ((cmd_q.opcode == NETTLP_OPC_REG_RD || cmd_q.opcode == NETTLP_OPC_REG_WR) && !addr_ok) begin
          err_cnt_d      = sat_inc16(err_cnt_q);
          reply_d        = cmd_q;
          reply_d.opcode = NETTLP_OPC_REG_ERR;
          reply_d.data   = NETTLP_ERR_DATA;
          state_d        = ST_SEND;
        end else if (cmd_q.opcode == NETTLP_OPC_REG_RD) begin
          reply_d      = cmd_q;
          reply_d.data = rd_wire;
          state_d      = ST_SEND;
        end else if (cmd_q.opcode == NETTLP_OPC_REG_WR && is_ro) begin
          err_cnt_d = sat_inc16(err_cnt_q);
          if (WR_ACK) begin
            reply_d        = cmd_q;
            reply_d.opcode = NETTLP_OPC_REG_ERR;
            reply_d.data   = NETTLP_ERR_DATA;
            state_d        = ST_SEND;
          end
        end else if (cmd_q.opcode == NETTLP_OPC_REG_WR) begin
          bank_we = 1'b1;
          if (WR_ACK) begin
            reply_d      = cmd_q;
            reply_d.data = new_wire;
            state_d      = ST_SEND;
          end
        end else begin
          err_cnt_d = sat_inc16(err_cnt_q);
        end
      end
      ST_SEND: begin
        if (!fifo_cmd_o_full) begin
          fifo_cmd_o_wr_en = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes are combinational, so hold them off while reset is asserted.
    if (rst) begin
      fifo_cmd_i_rd_en = 1'b0;
      fifo_cmd_o_wr_en = 1'b0;
      bank_we          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      reply_q   <= '0;
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      reply_q   <= reply_d;
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign fifo_cmd_o_din = reply_q;
  assign stat_cmd_cnt   = cmd_cnt_q;
  assign stat_err_cnt   = err_cnt_q;

  nettlp_cmd_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RST_VAL  (RST_VAL)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .cmd_we    (bank_we),
    .cmd_idx   (idx),
    .cmd_be    (cmd_q.be),
    .cmd_wdata (wr_word),
    .hw_we     (hw_we),
    .hw_din    (hw_din),
    .reg_q     (reg_q)
  );

endmodule

// File: tb/tb_nettlp_cmd_regfile.sv
// Directed bench for nettlp_cmd_regfile: command table plus back-pressure,
// hardware-update collision and reset-in-SEND sequences.
module tb_nettlp_cmd_regfile;
  import nettlp_cmd_pkg::*;

  localparam int NR = 16;
  localparam logic [NR*32-1:0] RST_V = {{15{32'h0}}, 32'h01234567};

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_en;
  logic             empty;
  FIFO_NETTLP_CMD_T dout;
  logic             wr_en;
  logic             full;
  FIFO_NETTLP_CMD_T din;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    hw_we;
  logic [NR*32-1:0] hw_din;
  logic [15:0]      cmd_cnt;
  logic [15:0]      err_cnt;

  always #5 clk = ~clk;

  nettlp_cmd_regfile #(
    .NUM_REGS   (NR),
    .ADDR_W     (8),
    .RO_MASK    (16'h0001),
    .RST_VAL    (RST_V),
    .SWAP_BYTES (1'b1),
    .WR_ACK     (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_cmd_i_rd_en (rd_en),
    .fifo_cmd_i_empty (empty),
    .fifo_cmd_i_dout  (dout),
    .fifo_cmd_o_wr_en (wr_en),
    .fifo_cmd_o_full  (full),
    .fifo_cmd_o_din   (din),
    .reg_q            (reg_q),
    .hw_we            (hw_we),
    .hw_din           (hw_din),
    .stat_cmd_cnt     (cmd_cnt),
    .stat_err_cnt     (err_cnt)
  );

  // First-word-fall-through input FIFO model and reply capture
  FIFO_NETTLP_CMD_T in_mem [64];
  FIFO_NETTLP_CMD_T rep_mem[64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rep_cnt = 0;
  int wr_full_viol = 0;

  assign empty = (wr_ptr == rd_ptr);
  assign dout  = in_mem[rd_ptr % 64];

  always @(posedge clk) begin
    if (rd_en) rd_ptr <= rd_ptr + 1;
    if (wr_en && rep_cnt < 63) begin
      rep_mem[rep_cnt] <= din;
      rep_cnt <= rep_cnt + 1;
    end
    if (wr_en && full) wr_full_viol <= wr_full_viol + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input logic [7:0] opc, input logic [7:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
    in_mem[wr_ptr % 64] = {opc, addr, be, data};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct packed {
    logic [7:0]  opc;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exp_rep;
    logic [7:0]  exp_opc;
    logic [31:0] exp_data;
    logic        chk_data;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int rep0;
    int rd0;
    int t;
    FIFO_NETTLP_CMD_T r;

    vecs[0] = '{8'h01, 8'd0,  4'hF,    32'h0,        1'b1, NETTLP_OPC_REG_RD,  32'h67452301, 1'b1, 16'd0};
    vecs[1] = '{8'h02, 8'd3,  4'b0011, 32'hAABBCCDD, 1'b1, NETTLP_OPC_REG_WR,  32'hAABB0000, 1'b1, 16'd0};
    vecs[2] = '{8'h01, 8'd3,  4'hF,    32'h0,        1'b1, NETTLP_OPC_REG_RD,  32'hAABB0000, 1'b1, 16'd0};
    vecs[3] = '{8'h02, 8'd0,  4'hF,    32'hFFFFFFFF, 1'b1, NETTLP_OPC_REG_ERR, 32'h0,        1'b0, 16'd1};
    vecs[4] = '{8'h01, 8'd20, 4'hF,    32'h0,        1'b1, NETTLP_OPC_REG_ERR, 32'hDEADBEEF, 1'b1, 16'd2};
    vecs[5] = '{8'h7F, 8'd1,  4'hF,    32'h12345678, 1'b0, 8'h00,              32'h0,        1'b0, 16'd3};
    vecs[6] = '{8'h02, 8'd15, 4'b1100, 32'h11223344, 1'b1, NETTLP_OPC_REG_WR,  32'h00003344, 1'b1, 16'd3};
    vecs[7] = '{8'h01, 8'd15, 4'hF,    32'h0,        1'b1, NETTLP_OPC_REG_RD,  32'h00003344, 1'b1, 16'd3};
    vecs[8] = '{8'h02, 8'd16, 4'hF,    32'h0,        1'b1, NETTLP_OPC_REG_ERR, 32'hDEADBEEF, 1'b1, 16'd4};

    rst = 1'b1; full = 1'b0; hw_we = '0; hw_din = '0;
    settle(3);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_regs", 32'(reg_q == RST_V), 32'd1);
    rst = 1'b0;
    settle(2);

    for (int i = 0; i < 9; i++) begin
      rep0 = rep_cnt;
      rd0  = rd_ptr;
      push(vecs[i].opc, vecs[i].addr, vecs[i].be, vecs[i].data);
      settle(6);
      chk($sformatf("v%0d_pops", i), 32'(rd_ptr - rd0), 32'd1);
      chk($sformatf("v%0d_replies", i), 32'(rep_cnt - rep0), 32'(vecs[i].exp_rep));
      if (vecs[i].exp_rep && rep_cnt > rep0) begin
        r = rep_mem[rep0];
        chk($sformatf("v%0d_opc", i), 32'(r.opcode), 32'(vecs[i].exp_opc));
        chk($sformatf("v%0d_addr", i), 32'(r.dwaddr), 32'(vecs[i].addr));
        if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), r.data, vecs[i].exp_data);
      end
      chk($sformatf("v%0d_cmd_cnt", i), 32'(cmd_cnt), 32'(i + 1));
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
    end
    chk("reg3_value", reg_q[127:96], 32'h0000BBAA);
    chk("reg0_ro_kept", reg_q[31:0], 32'h01234567);
    chk("reg15_value", reg_q[511:480], 32'h44330000);

    // Back-pressure: reply held, second command stays queued
    full = 1'b1;
    rep0 = rep_cnt;
    rd0  = rd_ptr;
    push(NETTLP_OPC_REG_RD, 8'd3, 4'hF, 32'h0);
    push(NETTLP_OPC_REG_RD, 8'd0, 4'hF, 32'h0);
    settle(50);
    chk("full_no_reply", 32'(rep_cnt - rep0), 32'd0);
    chk("full_one_pop", 32'(rd_ptr - rd0), 32'd1);
    full = 1'b0;
    settle(10);
    chk("full_replies", 32'(rep_cnt - rep0), 32'd2);
    chk("full_pops", 32'(rd_ptr - rd0), 32'd2);
    chk("full_rep0_data", rep_mem[rep0].data, 32'hAABB0000);
    chk("full_rep1_data", rep_mem[rep0 + 1].data, 32'h67452301);
    chk("wr_while_full", 32'(wr_full_viol), 32'd0);

    // Hardware update ignores the read-only mask
    hw_we = 16'h0001;
    hw_din[31:0] = 32'hCAFEF00D;
    settle(1);
    hw_we = '0;
    settle(1);
    chk("hw_we_ro_reg", reg_q[31:0], 32'hCAFEF00D);

    // Command write and hardware update to register 5 in the same cycle
    rd0 = rd_ptr;
    push(NETTLP_OPC_REG_WR, 8'd5, 4'hF, 32'hA1B2C3D4);
    t = 0;
    while (rd_ptr == rd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("collide_pop_seen", 32'(t < 20), 32'd1);
    hw_we = 16'h0020;
    hw_din[191:160] = 32'h55555555;
    settle(1);
    hw_we = '0;
    settle(4);
    chk("collide_cmd_wins", reg_q[191:160], 32'hD4C3B2A1);

    // Reset while a reply is waiting in SEND
    full = 1'b1;
    rep0 = rep_cnt;
    push(NETTLP_OPC_REG_RD, 8'd0, 4'hF, 32'h0);
    settle(4);
    rst = 1'b1;
    settle(2);
    full = 1'b0;
    settle(2);
    rst = 1'b0;
    settle(10);
    chk("rst_send_no_wr", 32'(rep_cnt - rep0), 32'd0);
    chk("rst_send_regs", 32'(reg_q == RST_V), 32'd1);
    chk("rst_send_cmd_cnt", 32'(cmd_cnt), 32'd0);
    chk("rst_send_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_send_din", 32'(din), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
